// File: rtl/si_input_pkg.sv
// Shared definitions for the push-button input front end: channel indices,
// the per-channel auto-repeat state encoding and default timing constants.
package si_input_pkg;

    // Channel index of each game-control button within the raw/level vectors
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_SHOOT = 2;
    localparam int BTN_START = 3;

    // Default timing at 36 MHz: 10 ms debounce, 250 ms first repeat, 100 ms rate
    localparam int DEF_N_BUTTONS       = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 360000;
    localparam int DEF_REPEAT_DELAY    = 9000000;
    localparam int DEF_REPEAT_RATE     = 3600000;

    // Auto-repeat state of one channel
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Larger of two integers, used to size the shared repeat counter
    function automatic int max_int(input int a, input int b);
        int r;
        if (a > b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

    // Counter width that is never zero, even for tiny terminal counts
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce counter, press/release
// edge pulses and an optional auto-repeat FSM. All outputs are registered.
module debounce_channel
    import si_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rise_s, fall_s, fire_s;

    // Synchronizer, debounce state and output pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Debounce: any cycle of agreement restarts the count; a full run of disagreement flips level
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rise_s = level_d & ~level_q;
    assign fall_s = ~level_d & level_q;

    // Repeat FSM state and interval counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rpt_q   <= '0;
        end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
        end
    end

    // Repeat FSM next state; a falling level wins over a repeat due in the same cycle
    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        fire_s  = 1'b0;
        if (!REPEAT_EN) begin
            state_d = IDLE;
            rpt_d   = '0;
        end else if (fall_s) begin
            state_d = IDLE;
            rpt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise_s) begin
                        state_d = DELAY;
                        rpt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DELAY: begin
                    if (rpt_q == DELAY_LAST) begin
                        state_d = REPEAT;
                        rpt_d   = '0;
                        fire_s  = 1'b1;
                    end else begin
                        rpt_d = rpt_q + {{(RPT_W-1){1'b0}}, 1'b1};
                    end
                end
                REPEAT: begin
                    if (rpt_q == RATE_LAST) begin
                        rpt_d  = '0;
                        fire_s = 1'b1;
                    end else begin
                        rpt_d = rpt_q + {{(RPT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_d = IDLE;
                    rpt_d   = '0;
                end
            endcase
        end
    end

    // Pulse outputs: press on accepted rise or repeat, release on accepted fall
    always_comb begin
        press_d   = rise_s | fire_s;
        release_d = fall_s;
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Game input front end: one debounce_channel per push button. The release
// pulse port is called release_pulse because release is a reserved word.
module button_conditioner
    import si_input_pkg::*;
#(
    parameter int                   N_BUTTONS       = DEF_N_BUTTONS,
    parameter int                   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                   REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                   REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = N_BUTTONS'(4'b0011)
) (
    input  logic                 clk_36MHz,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] raw,
    output logic [N_BUTTONS-1:0] level,
    output logic [N_BUTTONS-1:0] press,
    output logic [N_BUTTONS-1:0] release_pulse
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .REPEAT_EN      (REPEAT_MASK[i])
        ) u_ch (
            .clk          (clk_36MHz),
            .reset        (reset),
            .raw          (raw[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short timing constants.
module tb_button_conditioner;
    import si_input_pkg::*;

    logic       clk_36MHz = 1'b0;
    logic       reset;
    logic [3:0] raw;
    logic [3:0] level, press, release_pulse;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    button_conditioner #(
        .N_BUTTONS      (4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3),
        .REPEAT_MASK    (4'b0011)
    ) dut (
        .clk_36MHz    (clk_36MHz),
        .reset        (reset),
        .raw          (raw),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse)
    );

    always #5 clk_36MHz = ~clk_36MHz;

    always @(posedge clk_36MHz) cyc <= cyc + 1;

    task automatic exp_ev(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.level = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk_36MHz);
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every output pulse must match the next expected event
    always @(negedge clk_36MHz) begin
        if ((press | release_pulse) != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cyc %0d press=%b release=%b level=%b, none expected",
                         cyc, press, release_pulse, level);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.press !== press ||
                    mon_e.rel !== release_pulse || mon_e.level !== level) begin
                    errors++;
                    $display("FAIL event: got cyc %0d press=%b release=%b level=%b expected cyc %0d press=%b release=%b level=%b",
                             cyc, press, release_pulse, level,
                             mon_e.cyc, mon_e.press, mon_e.rel, mon_e.level);
                end
            end
        end
    end

    initial begin
        int t0;
        reset = 1'b1;
        raw   = 4'b0000;
        repeat (3) @(negedge clk_36MHz);
        check4("reset_level",   level,         4'b0000);
        check4("reset_press",   press,         4'b0000);
        check4("reset_release", release_pulse, 4'b0000);
        reset = 1'b0;
        repeat (2) @(negedge clk_36MHz);

        // Clean press and release on shoot
        t0 = cyc + 1;
        raw[BTN_SHOOT] = 1'b1;
        exp_ev(t0 + 5, 4'b0100, 4'b0000, 4'b0100);
        wait_cyc(t0 + 19);
        raw[BTN_SHOOT] = 1'b0;
        exp_ev(t0 + 25, 4'b0000, 4'b0100, 4'b0000);
        wait_cyc(t0 + 40);

        // Bounce on start, then stable high from edge 10
        t0 = cyc + 1;
        for (int i = 0; i <= 10; i++) begin
            wait_cyc(t0 + i - 1);
            raw[BTN_START] = (i == 10) || (i % 2 == 0);
        end
        exp_ev(t0 + 15, 4'b1000, 4'b0000, 4'b1000);
        wait_cyc(t0 + 29);
        raw[BTN_START] = 1'b0;
        exp_ev(t0 + 35, 4'b0000, 4'b1000, 4'b0000);
        wait_cyc(t0 + 50);

        // Three-cycle glitch on left must produce nothing
        t0 = cyc + 1;
        raw[BTN_LEFT] = 1'b1;
        wait_cyc(t0 + 2);
        raw[BTN_LEFT] = 1'b0;
        wait_cyc(t0 + 20);
        check4("glitch_level", level, 4'b0000);

        // Auto-repeat on left, single press on shoot; fall suppresses the repeat due at +30
        t0 = cyc + 1;
        raw = 4'b0101;
        exp_ev(t0 + 5, 4'b0101, 4'b0000, 4'b0101);
        for (int k = 0; k < 5; k++) begin
            exp_ev(t0 + 15 + 3 * k, 4'b0001, 4'b0000, 4'b0101);
        end
        wait_cyc(t0 + 24);
        raw = 4'b0000;
        exp_ev(t0 + 30, 4'b0000, 4'b0101, 4'b0000);
        wait_cyc(t0 + 50);

        // Simultaneous right and shoot
        t0 = cyc + 1;
        raw = 4'b0110;
        exp_ev(t0 + 5,  4'b0110, 4'b0000, 4'b0110);
        exp_ev(t0 + 15, 4'b0010, 4'b0000, 4'b0110);
        exp_ev(t0 + 18, 4'b0010, 4'b0000, 4'b0110);
        exp_ev(t0 + 21, 4'b0010, 4'b0000, 4'b0110);
        wait_cyc(t0 + 16);
        raw = 4'b0000;
        exp_ev(t0 + 22, 4'b0000, 4'b0110, 4'b0000);
        wait_cyc(t0 + 45);

        // Reset during a hold on right
        t0 = cyc + 1;
        raw[BTN_RIGHT] = 1'b1;
        exp_ev(t0 + 5, 4'b0010, 4'b0000, 4'b0010);
        wait_cyc(t0 + 11);
        check4("pre_reset_level", level, 4'b0010);
        reset = 1'b1;
        #1;
        check4("midreset_level",   level,         4'b0000);
        check4("midreset_press",   press,         4'b0000);
        check4("midreset_release", release_pulse, 4'b0000);
        wait_cyc(t0 + 13);
        reset = 1'b0;
        exp_ev(t0 + 19, 4'b0010, 4'b0000, 4'b0010);
        wait_cyc(t0 + 20);
        raw[BTN_RIGHT] = 1'b0;
        exp_ev(t0 + 26, 4'b0000, 4'b0010, 4'b0000);
        wait_cyc(t0 + 40);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected pulses never seen, first at cyc %0d",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
